t_chain: RTL

- Forward-kinematics accumulator that sits directly downstream of the per-joint DH transform stage.
- Consumes a stream of 4x4 homogeneous transform matrices, one per joint. The values are 27-bit two's-complement fixed point with 8 fractional bits, so 256 = 1.0.
- Folds the stream into a running product P = T1·T2·…·Tn and presents the final end-effector pose matrix when the joint tagged last has been folded in.
- Uses one time-shared 4-multiplier dot-product unit, producing one result entry per cycle.

---
 rtl/t_chain_if.sv | 24 ++
 rtl/t_chain.sv | 121 ++++++++++++
 2 files changed

// File: rtl/t_chain_if.sv
// Stream bundle for t_chain: incoming joint transforms and the outgoing end-effector pose.
interface t_chain_if #(
  parameter int WIDTH = 27,
  parameter int CW    = 4
) ();
  logic [16*WIDTH-1:0] t_matrix;
  logic                t_valid;
  logic                t_last;
  logic                t_ready;
  logic [16*WIDTH-1:0] pose_matrix;
  logic                pose_valid;
  logic                pose_ready;
  logic [CW-1:0]       joint_count;

  modport master (
    output t_matrix, t_valid, t_last, pose_ready,
    input  t_ready, pose_matrix, pose_valid, joint_count
  );

  modport slave (
    input  t_matrix, t_valid, t_last, pose_ready,
    output t_ready, pose_matrix, pose_valid, joint_count
  );
endinterface

// File: rtl/t_chain.sv
// Forward-kinematics accumulator: folds a stream of 4x4 fixed-point transforms into a running
// product, one result entry per cycle through a shared 4-multiplier dot-product unit.
module t_chain #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 8,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  t_chain_if.slave   bus
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 2;
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {ACCEPT, MUL, DONE} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] a_q [16];
  logic signed [WIDTH-1:0] a_d [16];
  logic signed [WIDTH-1:0] t_q [16];
  logic signed [WIDTH-1:0] t_d [16];
  logic signed [WIDTH-1:0] n_q [16];
  logic signed [WIDTH-1:0] n_d [16];
  logic [3:0]              k_q, k_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           jc_q, jc_d;

  logic signed [PW-1:0]    prod [4];
  logic signed [SW-1:0]    sum;
  logic signed [WIDTH-1:0] entry;

  // Dot product of row k/4 of A with column k%4 of T, rounded to nearest at the FRAC boundary.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      prod[j] = PW'(a_q[{k_q[3:2], 2'(j)}]) * PW'(t_q[{2'(j), k_q[1:0]}]);
    end
    sum   = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) + SW'(prod[3]);
    entry = WIDTH'(sum >>> FRAC) + WIDTH'(sum[FRAC-1]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    t_d     = t_q;
    n_d     = n_q;
    k_d     = k_q;
    last_d  = last_q;
    jc_d    = jc_q;
    if (en) begin
      case (state_q)
        ACCEPT: begin
          if (bus.t_valid) begin
            for (int i = 0; i < 16; i++) begin
              t_d[i] = bus.t_matrix[WIDTH*i +: WIDTH];
            end
            last_d  = bus.t_last;
            k_d     = '0;
            state_d = MUL;
          end
        end
        MUL: begin
          n_d[k_q] = entry;
          k_d      = k_q + 1'b1;
          if (k_q == 4'd15) begin
            a_d     = n_q;
            a_d[15] = entry;
            if (jc_q != {CW{1'b1}}) begin
              jc_d = jc_q + 1'b1;
            end
            state_d = last_q ? DONE : ACCEPT;
          end
        end
        DONE: begin
          if (bus.pose_ready) begin
            for (int i = 0; i < 16; i++) begin
              a_d[i] = (i % 5 == 0) ? ONE : '0;
            end
            jc_d    = '0;
            state_d = ACCEPT;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ACCEPT;
      for (int i = 0; i < 16; i++) begin
        a_q[i] <= (i % 5 == 0) ? ONE : '0;
        t_q[i] <= '0;
        n_q[i] <= '0;
      end
      k_q    <= '0;
      last_q <= 1'b0;
      jc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      t_q     <= t_d;
      n_q     <= n_d;
      k_q     <= k_d;
      last_q  <= last_d;
      jc_q    <= jc_d;
    end
  end

  always_comb begin
    bus.t_ready     = (state_q == ACCEPT);
    bus.pose_valid  = (state_q == DONE);
    bus.joint_count = jc_q;
    for (int i = 0; i < 16; i++) begin
      bus.pose_matrix[WIDTH*i +: WIDTH] = a_q[i];
    end
  end

endmodule
